// File: rtl/mvm_ctrl_pkg.sv
// Shared types and defaults for the MVM batch controller: FSM state encoding,
// the per-word accumulator flag bundle, and the default datapath latency.
package mvm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic accum_first;
    logic accum_last;
    logic ovalid;
  } flags_t;

  localparam int DEFAULT_PIPE_LAT = 11;

endpackage

// File: rtl/mvm_flag_delay.sv
// PIPE_LAT-deep shift register that delays per-word accumulator flags so they
// line up with the datapath result of the read issued PIPE_LAT cycles earlier.
module mvm_flag_delay
  import mvm_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = DEFAULT_PIPE_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  flags_t flags_i,
  output flags_t flags_o
);

  flags_t [PIPE_LAT-1:0] pipe_q;

  // Shifts every cycle; memory back-pressure never freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= flags_i;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign flags_o = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/mvm_batch_ctrl.sv
// Batch control FSM for the MVM engine: walks batch/row/word address loops for one
// command and delays accumulator flags. Optional STALL_CNT_EN adds a stall-cycle counter.
module mvm_batch_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int VEC_ADDRW = 8,
  parameter int MAT_ADDRW = 9,
  parameter int VEC_SIZEW = VEC_ADDRW + 1,
  parameter int MAT_SIZEW = MAT_ADDRW + 1,
  parameter int BATCH_W   = 4,
  parameter int PIPE_LAT  = DEFAULT_PIPE_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_SIZEW-1:0] vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  input  logic [BATCH_W-1:0]   num_batches,
  input  logic                 stall,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 raddr_valid,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic                 ovalid,
  output logic                 busy,
  output logic                 done,
`ifdef STALL_CNT_EN
  output logic [31:0]          stall_cycles,
`endif
  output state_e               fsm_state
);

  localparam int DCNT_W = $clog2(PIPE_LAT + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_valid is
  // ignored at all other times.
  state_e state_q, state_d;

  logic [VEC_ADDRW-1:0] vec_base_q, vec_raddr_q;
  logic [MAT_ADDRW-1:0] mat_start_q, mat_raddr_q;
  logic [VEC_SIZEW-1:0] words_q, w_q;
  logic [MAT_SIZEW-1:0] rows_q, r_q;
  logic [BATCH_W-1:0]   batches_q, b_q;
  logic [DCNT_W-1:0]    dcnt_q;
  logic                 done_q;

  logic   cmd_fire, null_cmd, issue;
  logic   last_word, last_row, last_batch, last_issue, drain_end;
  flags_t flags_in, flags_out;
  logic [VEC_ADDRW-1:0] words_lo;

  assign cmd_fire   = cmd_valid & (state_q == IDLE);
  assign null_cmd   = (num_batches == '0) | (vec_num_words == '0) |
                      (mat_num_rows_per_olane == '0);
  assign issue      = (state_q == RUN) & ~stall;
  assign last_word  = (w_q == words_q - VEC_SIZEW'(1));
  assign last_row   = (r_q == rows_q - MAT_SIZEW'(1));
  assign last_batch = (b_q == batches_q - BATCH_W'(1));
  assign last_issue = issue & last_word & last_row & last_batch;
  assign drain_end  = (state_q == DRAIN) & (dcnt_q == DRAIN_LAST);
  assign words_lo   = words_q[VEC_ADDRW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = null_cmd ? DRAIN : RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready            = (state_q == IDLE);
    busy                 = (state_q != IDLE);
    raddr_valid          = issue;
    flags_in             = '0;
    flags_in.ovalid      = issue;
    flags_in.accum_first = issue & (w_q == '0);
    flags_in.accum_last  = issue & last_word;
  end

  // Loop counters and address registers. The matrix address runs continuously
  // through a batch; the vector address rewinds to the batch base per row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_base_q  <= '0;
      vec_raddr_q <= '0;
      mat_start_q <= '0;
      mat_raddr_q <= '0;
      words_q     <= '0;
      rows_q      <= '0;
      batches_q   <= '0;
      w_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
      dcnt_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= drain_end;
      dcnt_q <= (state_q == DRAIN) ? dcnt_q + DCNT_W'(1) : '0;
      if (cmd_fire) begin
        words_q     <= vec_num_words;
        rows_q      <= mat_num_rows_per_olane;
        batches_q   <= num_batches;
        w_q         <= '0;
        r_q         <= '0;
        b_q         <= '0;
        vec_base_q  <= vec_start_addr;
        vec_raddr_q <= vec_start_addr;
        mat_start_q <= mat_start_addr;
        mat_raddr_q <= mat_start_addr;
      end else if (issue) begin
        if (!last_word) begin
          w_q         <= w_q + VEC_SIZEW'(1);
          vec_raddr_q <= vec_raddr_q + VEC_ADDRW'(1);
          mat_raddr_q <= mat_raddr_q + MAT_ADDRW'(1);
        end else if (!last_row) begin
          w_q         <= '0;
          r_q         <= r_q + MAT_SIZEW'(1);
          vec_raddr_q <= vec_base_q;
          mat_raddr_q <= mat_raddr_q + MAT_ADDRW'(1);
        end else begin
          w_q         <= '0;
          r_q         <= '0;
          b_q         <= b_q + BATCH_W'(1);
          vec_base_q  <= vec_base_q + words_lo;
          vec_raddr_q <= vec_base_q + words_lo;
          mat_raddr_q <= mat_start_q;
        end
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (cmd_fire) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

  mvm_flag_delay #(
    .PIPE_LAT(PIPE_LAT)
  ) u_flag_delay (
    .clk    (clk),
    .rst_n  (rst),
    .flags_i(flags_in),
    .flags_o(flags_out)
  );

  assign vec_raddr   = vec_raddr_q;
  assign mat_raddr   = mat_raddr_q;
  assign accum_first = flags_out.accum_first;
  assign accum_last  = flags_out.accum_last;
  assign ovalid      = flags_out.ovalid;
  assign done        = done_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_mvm_batch_ctrl.sv
// Scoreboard bench for mvm_batch_ctrl: directed and random commands, address and
// flag streams predicted from loop arithmetic, checked by an independent monitor.
module tb_mvm_batch_ctrl;
  import mvm_ctrl_pkg::*;

  localparam int VA = 8;
  localparam int MA = 9;
  localparam int PL = 11;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [VA-1:0] vec_start_addr;
  logic [VA:0]   vec_num_words;
  logic [MA-1:0] mat_start_addr;
  logic [MA:0]   mat_num_rows_per_olane;
  logic [3:0]    num_batches;
  logic          stall;
  logic [VA-1:0] vec_raddr;
  logic [MA-1:0] mat_raddr;
  logic          raddr_valid, accum_first, accum_last, ovalid, busy, done;
  state_e        fsm_state;
`ifdef STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  mvm_batch_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .vec_start_addr        (vec_start_addr),
    .vec_num_words         (vec_num_words),
    .mat_start_addr        (mat_start_addr),
    .mat_num_rows_per_olane(mat_num_rows_per_olane),
    .num_batches           (num_batches),
    .stall                 (stall),
    .vec_raddr             (vec_raddr),
    .mat_raddr             (mat_raddr),
    .raddr_valid           (raddr_valid),
    .accum_first           (accum_first),
    .accum_last            (accum_last),
    .ovalid                (ovalid),
    .busy                  (busy),
    .done                  (done),
`ifdef STALL_CNT_EN
    .stall_cycles          (stall_cycles),
`endif
    .fsm_state             (fsm_state)
  );

  // clock / cycle counter
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [VA+MA-1:0] exp_q[$];
  logic [2:0]       exp_flag_q[$];
  int               exp_done_q[$];
  int               issue_cyc_q[$];
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_flag_q.delete();
    exp_done_q.delete();
    issue_cyc_q.delete();
  endtask

  // monitor
  logic [VA+MA-1:0] mon_e;
  logic [2:0]       mon_fl;
  always @(negedge clk) begin
    if (rst) begin
      if (raddr_valid) begin
        chk("addr_expected", exp_q.size() != 0, 1);
        chk("no_issue_in_stall", stall, 0);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("vec_raddr", vec_raddr, mon_e[VA+MA-1:MA]);
          chk("mat_raddr", mat_raddr, mon_e[MA-1:0]);
        end
        issue_cyc_q.push_back(cyc);
      end
      mon_fl = {accum_first, accum_last, ovalid};
      if (mon_fl != 3'b000) begin
        chk("flag_expected", exp_flag_q.size() != 0, 1);
        if (exp_flag_q.size() != 0) chk("flags_fst_lst_ov", mon_fl, exp_flag_q.pop_front());
        if (issue_cyc_q.size() != 0) chk("flag_latency", cyc - issue_cyc_q.pop_front(), PL);
      end
      if (done) begin
        chk("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) chk("done_cycle", cyc, exp_done_q.pop_front());
        chk("done_busy", busy, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_addr_left", exp_q.size(), 0);
        chk("done_flags_left", exp_flag_q.size(), 0);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr_valid", raddr_valid, 0);
    chk("rst_vec_raddr", vec_raddr, 0);
    chk("rst_mat_raddr", mat_raddr, 0);
    chk("rst_flags", {accum_first, accum_last, ovalid}, 0);
    chk("rst_state", fsm_state, IDLE);
`ifdef STALL_CNT_EN
    chk("rst_stall_cycles", stall_cycles, 0);
`endif
  endtask

  task automatic wait_done(input bit rnd);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (rnd) stall = 1'($urandom_range(0, 1));
      if (done) begin
        seen = 1;
        break;
      end
    end
    stall = 1'b0;
    chk("done_seen", seen, 1);
    if (!seen) flush_model();
  endtask

  task automatic drive_fields(input int vs, input int nw, input int ms, input int nr, input int nb);
    vec_start_addr         = VA'(vs);
    vec_num_words          = (VA+1)'(nw);
    mat_start_addr         = MA'(ms);
    mat_num_rows_per_olane = (MA+1)'(nr);
    num_batches            = 4'(nb);
  endtask

  // issues one command, pushes its predicted stream, returns cycle after accept
  task automatic send_cmd(input int vs, input int nw, input int ms, input int nr,
                          input int nb, output int a);
    int i = 0;
    while (!cmd_ready && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    drive_fields(vs, nw, ms, nr, nb);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    a = cyc;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < nr; r++)
        for (int w = 0; w < nw; w++) begin
          exp_q.push_back({VA'((vs + b * nw + w) % (1 << VA)), MA'((ms + r * nw + w) % (1 << MA))});
          exp_flag_q.push_back({w == 0, w == nw - 1, 1'b1});
        end
  endtask

  task automatic run_cmd(input int vs, input int nw, input int ms, input int nr,
                         input int nb, input logic [31:0] mask, input bit rnd);
    int a, n, issued, stalls, i;
    bit s;
    send_cmd(vs, nw, ms, nr, nb, a);
    n = nb * nw * nr;
    issued = 0;
    stalls = 0;
    i = 0;
    while (issued < n) begin
      s = (i < 32 && mask[i % 32]) || (rnd && i < 500 && $urandom_range(0, 3) == 0);
      stall = s;
      if (rnd) begin
        cmd_valid = ($urandom_range(0, 2) == 0);
        drive_fields($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 511),
                     $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if (s) stalls++;
      else issued++;
      i++;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    cmd_valid = 1'b0;
    exp_done_q.push_back(a + n + stalls + PL);
    wait_done(rnd);
`ifdef STALL_CNT_EN
    chk("stall_cycles", stall_cycles, stalls);
`endif
  endtask

  task automatic abort_test();
    int a, dcount;
    send_cmd(0, 4, 8, 2, 1, a);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_reset_outputs();
    flush_model();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_abort", dcount, 0);
    #1;
    run_cmd(0, 4, 8, 2, 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    stall = 1'b0;
    drive_fields(0, 0, 0, 0, 0);
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;

    run_cmd(0, 4, 8, 2, 1, 0, 0);          // basic 2-row command
    run_cmd(10, 2, 0, 1, 3, 0, 0);         // 3 batches, matrix restarts
    run_cmd(0, 4, 8, 2, 1, 32'h6, 0);      // stall at T+2, T+3
    run_cmd(254, 4, 0, 1, 1, 0, 0);        // vector address wrap
    run_cmd(0, 4, 8, 2, 0, 0, 0);          // null: zero batches
    run_cmd(5, 0, 3, 2, 2, 0, 0);          // null: zero words
    run_cmd(5, 3, 3, 0, 2, 0, 0);          // null: zero rows
    run_cmd(0, 1, 510, 3, 2, 0, 0);        // 1-word rows, matrix wrap
    abort_test();

    for (int k = 0; k < 25; k++) begin
      run_cmd($urandom_range(0, 255),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6),
              $urandom_range(0, 511),
              $urandom_range(1, 3),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
              0, 1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
